invader_march_ctrl: RTL and testbench
=====================================

# invader_march_ctrl

Parametrised alien-formation movement controller for the Space Invaders game. It replaces the fixed left/right/down sequencer. Each qualifying movement tick advances the whole formation one horizontal step. At a screen limit it descends one row instead and reverses direction. March speed scales with the number of surviving invaders, and the block flags when the formation lands. It sits between the game timing tick generator and the sprite/renderer position registers.

## Interface
Parameters:
- XW, 10: width of `pos_x`.
- YW, 9: width of `pos_y`.
- AW, 6: width of `alive`.
- X_INIT, 64: formation x after start.
- Y_INIT, 32: formation y after start.
- X_MIN, 16: leftmost legal x.
- X_MAX, 400: rightmost legal x.
- H_STEP, 4: horizontal step in pixels.
- V_STEP, 16: descent step in pixels.
- Y_LAND, 384: y at or beyond which the formation has landed.
- SPD_SH, 2: speed shift. Reload = `alive >> SPD_SH`.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; initialises position and begins marching.
- mueva  in  1  one-cycle movement tick from the timing generator.
- freeze  in  1  level; while high, ticks are ignored (player-death pause).
- alive  in  AW  number of surviving invaders, sampled at each step.
- pos_x  out  XW  formation x offset.
- pos_y  out  YW  formation y offset.
- dir  out  1  1 = moving right, 0 = moving left.
- step_r, step_l, step_d  out  1  one-cycle pulses marking a right, left or down step.
- landed  out  1  level; formation has reached Y_LAND.

## Operation
- States:
  - IDLE: position held, ticks ignored.
  - MARCH: normal movement.
  - LANDED: position frozen, `landed` = 1.
- Reset (RST low at a clock edge):
  - state IDLE, pos_x = X_INIT, pos_y = Y_INIT, dir = 1.
  - step pulses 0, landed 0, speed counter cnt = 0.
- Start:
  - `start` in any state reloads pos_x, pos_y and dir to their reset values.
  - It loads cnt = alive >> SPD_SH, clears landed and enters MARCH.
  - If `start` and `mueva` arrive in the same cycle, start wins and the tick is discarded.
- Qualifying tick: `mueva` = 1 in MARCH with freeze = 0 and alive ≠ 0.
  - If cnt ≠ 0: cnt decrements and nothing else changes.
  - If cnt = 0: the formation steps and cnt reloads with `alive >> SPD_SH`, using the current `alive`.
- Step when dir = 1:
  - If pos_x + H_STEP ≤ X_MAX: pos_x += H_STEP and step_r pulses.
  - Otherwise: descend. pos_y += V_STEP, dir ← 0, step_d pulses, pos_x unchanged.
- Step when dir = 0:
  - If pos_x ≥ X_MIN + H_STEP: pos_x −= H_STEP and step_l pulses.
  - Otherwise: descend, dir ← 1.
- Landing: if a descent makes the new pos_y ≥ Y_LAND, the next state is LANDED and landed = 1 in the same cycle that step_d is asserted.
- alive = 0 (wave cleared): no steps occur and cnt holds.
- freeze high: ticks are ignored entirely and cnt holds.
- Arithmetic:
  - All comparisons are unsigned, carried out at XW+1 / YW+1 bits so they cannot wrap.
  - pos_x never leaves [X_MIN, X_MAX] once started.
- In LANDED only `start` or reset has any effect.
- Exactly one of step_r, step_l, step_d pulses per step; none pulse otherwise.

## Timing
- All outputs are registered.
- The step pulse and updated pos_x/pos_y/dir become visible together, in the cycle after the edge that samples the qualifying tick.
- Latency from a tick to its step is 1 cycle.
- With reload R, steps occur every R+1 qualifying ticks.
- Step pulses last exactly one cycle. Back-to-back steps are possible when R = 0 and ticks arrive on consecutive cycles.
- Reset mid-march takes effect at the next clock edge regardless of tick, freeze or start.

## Structure
- A shared package `march_pkg` holds:
  - the state enum (IDLE, MARCH, LANDED);
  - the default position and limit constants;
  - the direction encodings DIR_R = 1 and DIR_L = 0.
- One sub-module, `march_tick_div`: the alive-scaled reload counter. Its inputs are the tick qualifier, a load strobe and `alive`; its output is a `fire` strobe.
- The FSM and position datapath live in the top module.

## Test plan
- Reset: hold RST low for 2 cycles → pos_x = 64, pos_y = 32, dir = 1, landed = 0, no pulses. 10 ticks afterwards with no start → no change.
- Speed: start with alive = 8 (R = 2) → the 3rd tick produces step_r and pos_x = 68. Then set alive = 3 (R = 0 at the next reload) → the step after next follows on consecutive ticks.
- Right edge: march from 64 → after 84 steps pos_x = 400. The 85th step gives step_d, pos_y = 48, dir = 0, pos_x = 400. The next step gives step_l, pos_x = 396.
- Landing: continue to the 22nd descent → pos_y = 384 and landed = 1 with step_d. Further ticks cause no change. `start` then restores 64/32/dir = 1 and landed = 0.
- Gating: freeze high for 5 ticks, or alive = 0 for 5 ticks → cnt and position unchanged. `start` and `mueva` in the same cycle → no step, cnt loaded.
- Reset mid-march: RST low in the cycle of a qualifying tick → no pulse, outputs return to their reset values.

Source files
------------

// File: rtl/invader_march_ctrl_pkg.sv
// Shared types and defaults for the invader formation march controller.
package march_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MARCH  = 2'd1,
        LANDED = 2'd2
    } state_t;

    localparam int unsigned X_INIT_DEF = 64;
    localparam int unsigned Y_INIT_DEF = 32;
    localparam int unsigned X_MIN_DEF  = 16;
    localparam int unsigned X_MAX_DEF  = 400;
    localparam int unsigned H_STEP_DEF = 4;
    localparam int unsigned V_STEP_DEF = 16;
    localparam int unsigned Y_LAND_DEF = 384;
    localparam int unsigned SPD_SH_DEF = 2;

    localparam logic DIR_R = 1'b1;
    localparam logic DIR_L = 1'b0;

endpackage

// File: rtl/invader_march_ctrl_if.sv
// Control/position bundle between the timing generator, the march controller and the renderer.
interface invader_march_ctrl_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9,
    parameter int unsigned AW = 6
);
    logic          start;
    logic          mueva;
    logic          freeze;
    logic [AW-1:0] alive;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          dir;
    logic          step_r;
    logic          step_l;
    logic          step_d;
    logic          landed;

    modport master (
        output start, mueva, freeze, alive,
        input  pos_x, pos_y, dir, step_r, step_l, step_d, landed
    );

    modport slave (
        input  start, mueva, freeze, alive,
        output pos_x, pos_y, dir, step_r, step_l, step_d, landed
    );
endinterface

// File: rtl/invader_march_ctrl_tick_div.sv
// Alive-scaled tick divider: fires on the qualifying tick that finds the counter at zero.
module march_tick_div #(
    parameter int unsigned AW     = 6,
    parameter int unsigned SPD_SH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          qual,
    input  logic          load,
    input  logic [AW-1:0] alive,
    output logic          fire
);
    logic [AW-1:0] cnt;
    logic [AW-1:0] reload;

    assign reload = alive >> SPD_SH;
    assign fire   = qual && !load && (cnt == '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (qual) begin
            cnt <= (cnt == '0) ? reload : cnt - AW'(1);
        end
    end
endmodule

// File: rtl/invader_march_ctrl.sv
// Formation movement FSM and position datapath; step cadence comes from march_tick_div.
module invader_march_ctrl
    import march_pkg::*;
#(
    parameter int unsigned XW     = 10,
    parameter int unsigned YW     = 9,
    parameter int unsigned AW     = 6,
    parameter int unsigned X_INIT = X_INIT_DEF,
    parameter int unsigned Y_INIT = Y_INIT_DEF,
    parameter int unsigned X_MIN  = X_MIN_DEF,
    parameter int unsigned X_MAX  = X_MAX_DEF,
    parameter int unsigned H_STEP = H_STEP_DEF,
    parameter int unsigned V_STEP = V_STEP_DEF,
    parameter int unsigned Y_LAND = Y_LAND_DEF,
    parameter int unsigned SPD_SH = SPD_SH_DEF
) (
    input logic                 CLK,
    input logic                 RST,
    invader_march_ctrl_if.slave bus
);
    // Limits widened by one bit so the edge tests cannot wrap.
    localparam logic [XW:0] X_MAX_W  = (XW+1)'(X_MAX);
    localparam logic [XW:0] X_LO_W   = (XW+1)'(X_MIN + H_STEP);
    localparam logic [XW:0] H_STEP_W = (XW+1)'(H_STEP);
    localparam logic [YW:0] V_STEP_W = (YW+1)'(V_STEP);
    localparam logic [YW:0] Y_LAND_W = (YW+1)'(Y_LAND);

    state_t        state, state_n;
    logic [XW-1:0] pos_x, pos_x_n;
    logic [YW-1:0] pos_y, pos_y_n;
    logic          dir, dir_n;
    logic          step_r, step_r_n, step_l, step_l_n, step_d, step_d_n;
    logic          landed, landed_n;
    logic          qual, fire, descend;
    logic [XW:0]   x_up, x_dn;
    logic [YW:0]   y_dn;

    assign qual = bus.mueva && (state == MARCH) && !bus.freeze && (bus.alive != '0);

    march_tick_div #(.AW(AW), .SPD_SH(SPD_SH)) u_div (
        .CLK   (CLK),
        .RST   (RST),
        .qual  (qual),
        .load  (bus.start),
        .alive (bus.alive),
        .fire  (fire)
    );

    assign x_up = {1'b0, pos_x} + H_STEP_W;
    assign x_dn = {1'b0, pos_x} - H_STEP_W;
    assign y_dn = {1'b0, pos_y} + V_STEP_W;

    always_comb begin
        state_n  = state;
        pos_x_n  = pos_x;
        pos_y_n  = pos_y;
        dir_n    = dir;
        step_r_n = 1'b0;
        step_l_n = 1'b0;
        step_d_n = 1'b0;
        landed_n = landed;
        descend  = 1'b0;
        if (bus.start) begin
            state_n  = MARCH;
            pos_x_n  = XW'(X_INIT);
            pos_y_n  = YW'(Y_INIT);
            dir_n    = DIR_R;
            landed_n = 1'b0;
        end else if (fire) begin
            if (dir == DIR_R) begin
                if (x_up <= X_MAX_W) begin
                    pos_x_n  = x_up[XW-1:0];
                    step_r_n = 1'b1;
                end else begin
                    descend = 1'b1;
                end
            end else begin
                if ({1'b0, pos_x} >= X_LO_W) begin
                    pos_x_n  = x_dn[XW-1:0];
                    step_l_n = 1'b1;
                end else begin
                    descend = 1'b1;
                end
            end
            if (descend) begin
                pos_y_n  = y_dn[YW-1:0];
                dir_n    = ~dir;
                step_d_n = 1'b1;
                if (y_dn >= Y_LAND_W) begin
                    state_n  = LANDED;
                    landed_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            pos_x  <= XW'(X_INIT);
            pos_y  <= YW'(Y_INIT);
            dir    <= DIR_R;
            step_r <= 1'b0;
            step_l <= 1'b0;
            step_d <= 1'b0;
            landed <= 1'b0;
        end else begin
            state  <= state_n;
            pos_x  <= pos_x_n;
            pos_y  <= pos_y_n;
            dir    <= dir_n;
            step_r <= step_r_n;
            step_l <= step_l_n;
            step_d <= step_d_n;
            landed <= landed_n;
        end
    end

    assign bus.pos_x  = pos_x;
    assign bus.pos_y  = pos_y;
    assign bus.dir    = dir;
    assign bus.step_r = step_r;
    assign bus.step_l = step_l;
    assign bus.step_d = step_d;
    assign bus.landed = landed;
endmodule

// File: tb/tb_invader_march_ctrl.sv
// Self-checking bench for invader_march_ctrl against a behavioural formation model.
module tb_invader_march_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    int m_x, m_y, m_dir, m_cnt, m_st, m_landed, m_r, m_l, m_d;

    invader_march_ctrl_if #(.XW(10), .YW(9), .AW(6)) bus ();

    invader_march_ctrl #(
        .XW(10), .YW(9), .AW(6), .X_INIT(64), .Y_INIT(32), .X_MIN(16), .X_MAX(400),
        .H_STEP(4), .V_STEP(16), .Y_LAND(384), .SPD_SH(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    function automatic logic [23:0] got();
        return {bus.pos_x, bus.pos_y, bus.dir, bus.step_r, bus.step_l, bus.step_d, bus.landed};
    endfunction

    function automatic logic [23:0] expv();
        return {10'(m_x), 9'(m_y), 1'(m_dir), 1'(m_r), 1'(m_l), 1'(m_d), 1'(m_landed)};
    endfunction

    // st: 0 idle, 1 marching, 2 landed
    task automatic model(input bit r, input bit s, input bit m, input bit f, input int a);
        bit desc;
        desc = 0;
        m_r = 0; m_l = 0; m_d = 0;
        if (!r) begin
            m_x = 64; m_y = 32; m_dir = 1; m_landed = 0; m_cnt = 0; m_st = 0;
        end else if (s) begin
            m_x = 64; m_y = 32; m_dir = 1; m_landed = 0; m_cnt = a / 4; m_st = 1;
        end else if (m_st == 1 && m && !f && a != 0) begin
            if (m_cnt > 0) m_cnt--;
            else begin
                m_cnt = a / 4;
                if (m_dir == 1) begin
                    if (m_x + 4 <= 400) begin m_x += 4; m_r = 1; end else desc = 1;
                end else begin
                    if (m_x >= 20) begin m_x -= 4; m_l = 1; end else desc = 1;
                end
                if (desc) begin
                    m_y += 16; m_dir = 1 - m_dir; m_d = 1;
                    if (m_y >= 384) begin m_st = 2; m_landed = 1; end
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit m, input bit f, input int a);
        @(negedge CLK);
        RST = r; bus.start = s; bus.mueva = m; bus.freeze = f; bus.alive = 6'(a);
        @(posedge CLK);
        model(r, s, m, f, a);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 0, 8);
        drive(0, 1, 1, 0, 8);
        checks++;
        if (got() !== 24'({10'd64, 9'd32, 1'b1, 4'b0000})) begin
            errors++; $display("FAIL reset_values: got %h exp %h", got(), {10'd64, 9'd32, 1'b1, 4'b0000});
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 0, 8);
            checks++;
            if (got() !== 24'({10'd64, 9'd32, 1'b1, 4'b0000})) begin
                errors++; $display("FAIL idle_ticks: tick %0d got %h exp %h", i, got(), expv());
            end
        end
    endtask

    task automatic test_speed();
        int steps_at[$];
        drive(1, 1, 0, 0, 8);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 1, 0, 8);
            checks++;
            if (got() !== expv()) begin
                errors++; $display("FAIL speed_r2: tick %0d got %h exp %h", i, got(), expv());
            end
        end
        checks++;
        if (bus.step_r !== 1'b1 || bus.pos_x !== 10'd68) begin
            errors++; $display("FAIL speed_third_tick: step_r %b pos_x %0d exp 1 68", bus.step_r, bus.pos_x);
        end
        for (int i = 4; i <= 8; i++) begin
            drive(1, 0, 1, 0, 3);
            if (bus.step_r === 1'b1) steps_at.push_back(i);
            checks++;
            if (got() !== expv()) begin
                errors++; $display("FAIL speed_r0: tick %0d got %h exp %h", i, got(), expv());
            end
        end
        checks++;
        if (steps_at.size() != 3 || steps_at[0] != 6 || steps_at[1] != 7) begin
            errors++; $display("FAIL speed_consecutive: got %0d steps first at %0d exp 3 steps at 6,7,8",
                               steps_at.size(), steps_at.size() > 0 ? steps_at[0] : -1);
        end
    endtask

    task automatic test_edges_and_landing();
        int descents;
        int guard;
        drive(1, 1, 0, 0, 3);
        for (int i = 0; i < 84; i++) drive(1, 0, 1, 0, 3);
        checks++;
        if (bus.pos_x !== 10'd400 || bus.step_r !== 1'b1) begin
            errors++; $display("FAIL right_edge_reach: pos_x %0d step_r %b exp 400 1", bus.pos_x, bus.step_r);
        end
        drive(1, 0, 1, 0, 3);
        checks++;
        if (got() !== 24'({10'd400, 9'd48, 1'b0, 4'b0010})) begin
            errors++; $display("FAIL right_edge_descend: got %h exp %h", got(), {10'd400, 9'd48, 1'b0, 4'b0010});
        end
        drive(1, 0, 1, 0, 3);
        checks++;
        if (got() !== 24'({10'd396, 9'd48, 1'b0, 4'b0100})) begin
            errors++; $display("FAIL left_step: got %h exp %h", got(), {10'd396, 9'd48, 1'b0, 4'b0100});
        end
        descents = 1;
        guard = 0;
        while (descents < 22 && guard < 4000) begin
            drive(1, 0, 1, 0, 3);
            guard++;
            if (bus.step_d === 1'b1) descents++;
            checks++;
            if (got() !== expv()) begin
                errors++; $display("FAIL march_track: tick %0d got %h exp %h", guard, got(), expv());
            end
        end
        checks++;
        if (descents != 22 || bus.pos_y !== 9'd384 || bus.landed !== 1'b1 || bus.step_d !== 1'b1) begin
            errors++; $display("FAIL landing: descents %0d pos_y %0d landed %b step_d %b exp 22 384 1 1",
                               descents, bus.pos_y, bus.landed, bus.step_d);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 3);
            checks++;
            if (got() !== expv() || bus.landed !== 1'b1) begin
                errors++; $display("FAIL landed_hold: got %h exp %h", got(), expv());
            end
        end
        drive(1, 1, 0, 0, 3);
        checks++;
        if (got() !== 24'({10'd64, 9'd32, 1'b1, 4'b0000})) begin
            errors++; $display("FAIL restart_after_land: got %h exp %h", got(), {10'd64, 9'd32, 1'b1, 4'b0000});
        end
    endtask

    task automatic test_gating();
        drive(1, 1, 0, 0, 8);
        drive(1, 0, 1, 0, 8);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 1, 8);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 0, 0);
        checks++;
        if (got() !== 24'({10'd64, 9'd32, 1'b1, 4'b0000})) begin
            errors++; $display("FAIL gated_hold: got %h exp %h", got(), {10'd64, 9'd32, 1'b1, 4'b0000});
        end
        drive(1, 0, 1, 0, 8);
        checks++;
        if (bus.step_r !== 1'b0) begin
            errors++; $display("FAIL gated_cnt_held: step_r %b exp 0", bus.step_r);
        end
        drive(1, 0, 1, 0, 8);
        checks++;
        if (bus.step_r !== 1'b1 || bus.pos_x !== 10'd68) begin
            errors++; $display("FAIL gated_resume: step_r %b pos_x %0d exp 1 68", bus.step_r, bus.pos_x);
        end
        drive(1, 1, 1, 0, 8);
        checks++;
        if (got() !== 24'({10'd64, 9'd32, 1'b1, 4'b0000})) begin
            errors++; $display("FAIL start_beats_tick: got %h exp %h", got(), {10'd64, 9'd32, 1'b1, 4'b0000});
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 1, 0, 8);
            checks++;
            if (got() !== expv()) begin
                errors++; $display("FAIL start_loads_cnt: tick %0d got %h exp %h", i, got(), expv());
            end
        end
    endtask

    task automatic test_reset_mid_march();
        drive(1, 1, 0, 0, 3);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 3);
        drive(0, 0, 1, 0, 3);
        checks++;
        if (got() !== 24'({10'd64, 9'd32, 1'b1, 4'b0000})) begin
            errors++; $display("FAIL reset_mid_march: got %h exp %h", got(), {10'd64, 9'd32, 1'b1, 4'b0000});
        end
        drive(1, 0, 1, 0, 3);
        checks++;
        if (got() !== expv()) begin
            errors++; $display("FAIL idle_after_reset: got %h exp %h", got(), expv());
        end
    endtask

    task automatic test_random();
        bit r, s, m, f;
        int a;
        drive(1, 1, 0, 0, 20);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 59) == 0);
            m = ($urandom_range(0, 1) == 1);
            f = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
            drive(r, s, m, f, a);
            checks++;
            if (got() !== expv()) begin
                errors++; $display("FAIL random: cycle %0d got %h exp %h", i, got(), expv());
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mueva = 1'b0; bus.freeze = 1'b0; bus.alive = '0;
        test_reset();
        test_speed();
        test_edges_and_landing();
        test_gating();
        test_reset_mid_march();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
